// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU ops plus a 32-step iterative mul/div sequencer
// that freezes the upstream pipeline and sends bubbles downstream while it runs.
module exe_stage #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            freeze_in,
  input  logic [XLEN-1:0] val1,
  input  logic [XLEN-1:0] val2,
  input  logic [3:0]      control,
  input  logic [XLEN-1:0] saved_val,
  input  logic [XLEN-1:0] pc,
  input  logic            mem_write,
  input  logic            is_LB_SB,
  input  logic            is_SW_SB,
  input  logic            cache_en,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  input  logic            halted,
  input  logic [1:0]      jump,
  input  logic [4:0]      dest_reg_num,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] saved_val_out,
  output logic [XLEN-1:0] pc_out,
  output logic [1:0]      jump_out,
  output logic [4:0]      dest_reg_num_out,
  output logic            is_LB_SB_out,
  output logic            is_SW_SB_out,
  output logic            mem_to_reg_out,
  output logic            halted_out,
  output logic            mem_write_out,
  output logic            cache_en_out,
  output logic            reg_write_out,
  output logic            freeze_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} seq_state_t;

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SLL  = 4'd6,  OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8,  OP_SLT  = 4'd9,  OP_SLTU = 4'd10, OP_MUL  = 4'd11;
  localparam logic [3:0] OP_MULH = 4'd12, OP_DIV  = 4'd13, OP_REM  = 4'd14, OP_PASS = 4'd15;

  function automatic logic [31:0] mag32(input logic [31:0] v);
    mag32 = v[31] ? (32'd0 - v) : v;
  endfunction

  // 33-bit magnitude so that |32'h80000000| stays positive in comparisons.
  function automatic logic [32:0] mag33(input logic [31:0] v);
    mag33 = v[31] ? (33'd0 - {1'b1, v}) : {1'b0, v};
  endfunction

  seq_state_t  state_r, state_nxt_s;
  logic [4:0]  count_r;
  logic [31:0] acc_r, lo_r, result_r;
  logic [32:0] opb_r;
  logic [3:0]  op_r;
  logic        neg_a_r, neg_b_r, dz_r;

  logic        is_multi_s, start_s, last_s, seq_stall_s, is_mul_s, sign_diff_s, div_ge_s;
  logic [32:0] mul_sum_s, div_shift_s;
  logic [31:0] div_diff_s, acc_nxt_s, lo_nxt_s, final_s, alu_s;
  logic [63:0] prod_s, prod_c_s;
  logic [4:0]  shamt_s;

  assign is_multi_s  = (control >= OP_MUL) && (control <= OP_REM);
  assign start_s     = (state_r == IDLE) && is_multi_s && !halted;
  assign last_s      = (count_r == 5'(ITER - 1));
  assign seq_stall_s = start_s || (state_r == BUSY);
  assign is_mul_s    = (op_r == OP_MUL) || (op_r == OP_MULH);
  assign sign_diff_s = neg_a_r ^ neg_b_r;
  assign shamt_s     = val2[4:0];

  // Sequencer next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start_s)    state_nxt_s = BUSY; else state_nxt_s = IDLE;
      BUSY:    if (last_s)     state_nxt_s = DONE; else state_nxt_s = BUSY;
      DONE:    if (!freeze_in) state_nxt_s = IDLE; else state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // One iteration: shift-add multiply or restoring shift-subtract divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r} + (lo_r[0] ? opb_r : 33'd0);
    div_shift_s = {acc_r, lo_r[31]};
    div_ge_s    = (div_shift_s >= opb_r);
    div_diff_s  = div_shift_s[31:0] - opb_r[31:0];
    if (is_mul_s) begin
      acc_nxt_s = mul_sum_s[32:1];
      lo_nxt_s  = {mul_sum_s[0], lo_r[31:1]};
    end else if (div_ge_s) begin
      acc_nxt_s = div_diff_s;
      lo_nxt_s  = {lo_r[30:0], 1'b1};
    end else begin
      acc_nxt_s = div_shift_s[31:0];
      lo_nxt_s  = {lo_r[30:0], 1'b0};
    end
  end

  // Sign correction of the final iteration's values.
  always_comb begin
    prod_s   = {acc_nxt_s, lo_nxt_s};
    prod_c_s = sign_diff_s ? (64'd0 - prod_s) : prod_s;
    case (op_r)
      OP_MUL:  final_s = prod_c_s[31:0];
      OP_MULH: final_s = prod_c_s[63:32];
      OP_DIV:  final_s = dz_r ? 32'hFFFF_FFFF : (sign_diff_s ? (32'd0 - lo_nxt_s) : lo_nxt_s);
      OP_REM:  final_s = neg_a_r ? (32'd0 - acc_nxt_s) : acc_nxt_s;
      default: final_s = 32'd0;
    endcase
  end

  // Sequencer datapath registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count_r  <= 5'd0;
      acc_r    <= 32'd0;
      lo_r     <= 32'd0;
      opb_r    <= 33'd0;
      op_r     <= 4'd0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      dz_r     <= 1'b0;
      result_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            lo_r    <= mag32(val1);
            opb_r   <= mag33(val2);
            acc_r   <= 32'd0;
            count_r <= 5'd0;
            op_r    <= control;
            neg_a_r <= val1[31];
            neg_b_r <= val2[31];
            dz_r    <= (val2 == 32'd0);
          end
        end
        BUSY: begin
          acc_r   <= acc_nxt_s;
          lo_r    <= lo_nxt_s;
          count_r <= count_r + 5'd1;
          if (last_s) result_r <= final_s;
        end
        default: result_r <= result_r;
      endcase
    end
  end

  // Result mux: registered sequencer result in DONE, otherwise single-cycle ALU.
  always_comb begin
    alu_s = 32'd0;
    if (state_r == DONE) begin
      alu_s = result_r;
    end else begin
      case (control)
        OP_ADD:  alu_s = val1 + val2;
        OP_SUB:  alu_s = val1 - val2;
        OP_AND:  alu_s = val1 & val2;
        OP_OR:   alu_s = val1 | val2;
        OP_XOR:  alu_s = val1 ^ val2;
        OP_NOR:  alu_s = ~(val1 | val2);
        OP_SLL:  alu_s = val1 << shamt_s;
        OP_SRL:  alu_s = val1 >> shamt_s;
        OP_SRA:  alu_s = $signed(val1) >>> shamt_s;
        OP_SLT:  alu_s = ($signed(val1) < $signed(val2)) ? 32'd1 : 32'd0;
        OP_SLTU: alu_s = (val1 < val2) ? 32'd1 : 32'd0;
        OP_PASS: alu_s = val2;
        default: alu_s = 32'd0;
      endcase
    end
  end

  assign alu_result       = alu_s;
  assign freeze_out       = seq_stall_s | freeze_in;
  assign saved_val_out    = saved_val;
  assign pc_out           = pc;
  assign jump_out         = jump;
  assign dest_reg_num_out = dest_reg_num;
  assign is_LB_SB_out     = is_LB_SB;
  assign is_SW_SB_out     = is_SW_SB;
  assign mem_to_reg_out   = mem_to_reg;
  assign halted_out       = halted;
  // Stalled cycles must leave a bubble in EXE/MEM.
  assign mem_write_out    = mem_write & ~freeze_out;
  assign cache_en_out     = cache_en & ~freeze_out;
  assign reg_write_out    = reg_write & ~freeze_out;

endmodule
